// File: rtl/regfile_mp.sv
// Dual-read / dual-write register file with write-through bypass and a runtime clear sweep.
// Optional hard-wired zero entry 0 is enabled with `define REGFILE_MP_ZERO_REG_EN.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] bus_a,
    output logic [DATA_W-1:0] bus_b,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] rw0,
    input  logic [ADDR_W-1:0] rw1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [1:0]        o_dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

`ifdef REGFILE_MP_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    clr_state_t        r_state;
    clr_state_t        w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_busy;
    logic              w_done;
    logic              w_wen0;
    logic              w_wen1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (clr_req) w_next_state = SWEEP;
            end
            SWEEP: begin
                w_busy = 1'b1;
                if (r_ptr == PTR_LAST) w_next_state = DONE;
            end
            DONE: begin
                w_done       = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Pointer parks on the last index rather than wrapping; a new sweep reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (r_state == IDLE && clr_req) begin
            r_ptr <= '0;
        end else if (r_state == SWEEP && r_ptr != PTR_LAST) begin
            r_ptr <= r_ptr + ADDR_W'(1);
        end
    end

    // Effective write enables double as bypass enables, so suppression rules apply to both.
    assign w_wen0 = rst_n && we0 && !w_busy && !(ZERO_REG && rw0 == '0);
    assign w_wen1 = rst_n && we1 && !w_busy && !(ZERO_REG && rw1 == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_busy) begin
            r_mem[r_ptr] <= '0;
        end else begin
            if (w_wen0) r_mem[rw0] <= wd0;
            if (w_wen1) r_mem[rw1] <= wd1;
        end
    end

    always_comb begin
        bus_a = r_mem[ra];
        if (w_wen1 && rw1 == ra) begin
            bus_a = wd1;
        end else if (w_wen0 && rw0 == ra) begin
            bus_a = wd0;
        end
        if (ZERO_REG && ra == '0) bus_a = '0;
    end

    always_comb begin
        bus_b = r_mem[rb];
        if (w_wen1 && rw1 == rb) begin
            bus_b = wd1;
        end else if (w_wen0 && rw0 == rb) begin
            bus_b = wd0;
        end
        if (ZERO_REG && rb == '0) bus_b = '0;
    end

    assign clr_busy    = w_busy;
    assign clr_done    = w_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: bypass, write priority, clear sweep, async reset.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  ra = '0, rb = '0, rw0 = '0, rw1 = '0;
    logic [31:0] wd0 = '0, wd1 = '0;
    logic        we0 = 1'b0, we1 = 1'b0, clr_req = 1'b0;
    logic [31:0] bus_a, bus_b;
    logic        clr_busy, clr_done;
    logic [1:0]  dbg_state;

    int n_pass = 0;
    int n_total = 0;

    regfile_mp #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .bus_a(bus_a), .bus_b(bus_b),
        .we0(we0), .we1(we1), .rw0(rw0), .rw1(rw1), .wd0(wd0), .wd1(wd1),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        n_total++; if (clr_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", clr_busy); else n_pass++;
        n_total++; if (clr_done !== 1'b0) $display("FAIL reset_done got %b exp 0", clr_done); else n_pass++;
        n_total++; if (dbg_state !== 2'd0) $display("FAIL reset_state got %0d exp 0", dbg_state); else n_pass++;
        ra = 5'd3; rb = 5'd31; #1;
        n_total++; if (bus_a !== 32'h0) $display("FAIL reset_entry3 got %h exp 0", bus_a); else n_pass++;
        n_total++; if (bus_b !== 32'h0) $display("FAIL reset_entry31 got %h exp 0", bus_b); else n_pass++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        we0 = 1'b1; rw0 = 5'd3; wd0 = 32'hDEADBEEF; ra = 5'd3; #1;
        n_total++; if (bus_a !== 32'hDEADBEEF) $display("FAIL bypass_same_cycle got %h exp deadbeef", bus_a); else n_pass++;
        tick();
        we0 = 1'b0; #1;
        n_total++; if (bus_a !== 32'hDEADBEEF) $display("FAIL bypass_committed got %h exp deadbeef", bus_a); else n_pass++;
    endtask

    task automatic test_same_addr();
        we0 = 1'b1; rw0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; rw1 = 5'd7; wd1 = 32'h22;
        rb = 5'd7; ra = 5'd7; #1;
        n_total++; if (bus_b !== 32'h22) $display("FAIL same_addr_bypass_b got %h exp 22", bus_b); else n_pass++;
        n_total++; if (bus_a !== 32'h22) $display("FAIL same_addr_bypass_a got %h exp 22", bus_a); else n_pass++;
        tick();
        we0 = 1'b0; we1 = 1'b0; #1;
        n_total++; if (bus_b !== 32'h22) $display("FAIL same_addr_commit got %h exp 22", bus_b); else n_pass++;
    endtask

    task automatic test_diff_addr();
        we0 = 1'b1; rw0 = 5'd9;  wd0 = 32'h99;
        we1 = 1'b1; rw1 = 5'd10; wd1 = 32'hAA;
        tick();
        we0 = 1'b0; we1 = 1'b0; ra = 5'd9; rb = 5'd10; #1;
        n_total++; if (bus_a !== 32'h99) $display("FAIL diff_addr_port0 got %h exp 99", bus_a); else n_pass++;
        n_total++; if (bus_b !== 32'hAA) $display("FAIL diff_addr_port1 got %h exp aa", bus_b); else n_pass++;
    endtask

    task automatic test_zero_reg();
        logic [31:0] exp_v;
`ifdef REGFILE_MP_ZERO_REG_EN
        exp_v = 32'h0;
`else
        exp_v = 32'hFFFFFFFF;
`endif
        we0 = 1'b1; rw0 = 5'd0; wd0 = 32'hFFFFFFFF; ra = 5'd0; #1;
        n_total++; if (bus_a !== exp_v) $display("FAIL zero_reg_bypass got %h exp %h", bus_a, exp_v); else n_pass++;
        tick();
        we0 = 1'b0; #1;
        n_total++; if (bus_a !== exp_v) $display("FAIL zero_reg_commit got %h exp %h", bus_a, exp_v); else n_pass++;
    endtask

    task automatic test_sweep();
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_idx = -1;
        for (int i = 1; i < 32; i++) begin
            we0 = 1'b1; rw0 = 5'(i); wd0 = 32'(i);
            tick();
        end
        we0 = 1'b0; ra = 5'd17; rb = 5'd31; #1;
        n_total++; if (bus_a !== 32'd17) $display("FAIL fill_entry17 got %h exp 11", bus_a); else n_pass++;
        n_total++; if (bus_b !== 32'd31) $display("FAIL fill_entry31 got %h exp 1f", bus_b); else n_pass++;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (clr_busy === 1'b1) busy_cnt++;
            if (clr_done === 1'b1) begin
                done_cnt++;
                done_idx = i;
            end
            if (i == 10) begin
                we0 = 1'b1; rw0 = 5'd5; wd0 = 32'h55; ra = 5'd5; #1;
                n_total++; if (bus_a !== 32'h0) $display("FAIL sweep_bypass_off got %h exp 0", bus_a); else n_pass++;
            end else begin
                we0 = 1'b0;
            end
            tick();
        end
        n_total++; if (busy_cnt !== 32) $display("FAIL sweep_busy_cycles got %0d exp 32", busy_cnt); else n_pass++;
        n_total++; if (done_cnt !== 1) $display("FAIL sweep_done_pulses got %0d exp 1", done_cnt); else n_pass++;
        n_total++; if (done_idx !== 32) $display("FAIL sweep_done_position got %0d exp 32", done_idx); else n_pass++;
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i); #1;
            n_total++; if (bus_a !== 32'h0) $display("FAIL sweep_cleared entry %0d got %h exp 0", i, bus_a); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_sweep();
        we0 = 1'b1; rw0 = 5'd12; wd0 = 32'h1234;
        we1 = 1'b1; rw1 = 5'd31; wd1 = 32'h77;
        tick();
        we0 = 1'b0; we1 = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_total++; if (clr_busy !== 1'b1) $display("FAIL mid_sweep_busy got %b exp 1", clr_busy); else n_pass++;
        rst_n = 1'b0; ra = 5'd31; rb = 5'd12; #1;
        n_total++; if (clr_busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", clr_busy); else n_pass++;
        n_total++; if (dbg_state !== 2'd0) $display("FAIL abort_state got %0d exp 0", dbg_state); else n_pass++;
        n_total++; if (bus_a !== 32'h0) $display("FAIL abort_entry31 got %h exp 0", bus_a); else n_pass++;
        n_total++; if (bus_b !== 32'h0) $display("FAIL abort_entry12 got %h exp 0", bus_b); else n_pass++;
        we0 = 1'b1; rw0 = 5'd20; wd0 = 32'hBAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (clr_done !== 1'b0) $display("FAIL abort_no_done got %b exp 0", clr_done); else n_pass++;
        end
        rst_n = 1'b1;
        rw0 = 5'd4; wd0 = 32'h44;
        tick();
        we0 = 1'b0;
        n_total++; if (clr_done !== 1'b0) $display("FAIL release_no_done got %b exp 0", clr_done); else n_pass++;
        for (int i = 0; i < 32; i++) begin
            logic [31:0] exp_v;
            exp_v = (i == 4) ? 32'h44 : 32'h0;
            ra = 5'(i); #1;
            n_total++; if (bus_a !== exp_v) $display("FAIL post_reset entry %0d got %h exp %h", i, bus_a, exp_v); else n_pass++;
        end
    endtask

    task automatic test_held_clr_req();
        int busy_cnt = 0;
        int done_cnt = 0;
        logic seen_done = 1'b0;
        clr_req = 1'b1;
        tick();
        for (int i = 0; i < 33; i++) begin
            if (clr_busy === 1'b1) busy_cnt++;
            if (clr_done === 1'b1) done_cnt++;
            tick();
        end
        n_total++; if (busy_cnt !== 32) $display("FAIL held_busy_cycles got %0d exp 32", busy_cnt); else n_pass++;
        n_total++; if (done_cnt !== 1) $display("FAIL held_done_pulses got %0d exp 1", done_cnt); else n_pass++;
        n_total++; if (dbg_state !== 2'd0) $display("FAIL held_back_to_idle got %0d exp 0", dbg_state); else n_pass++;
        n_total++; if (clr_busy !== 1'b0) $display("FAIL held_idle_busy got %b exp 0", clr_busy); else n_pass++;
        tick();
        clr_req = 1'b0;
        n_total++; if (clr_busy !== 1'b1) $display("FAIL held_restart got %b exp 1", clr_busy); else n_pass++;
        for (int i = 0; i < 40; i++) begin
            if (clr_done === 1'b1) seen_done = 1'b1;
            tick();
        end
        n_total++; if (seen_done !== 1'b1) $display("FAIL held_second_done timeout got %b exp 1", seen_done); else n_pass++;
        n_total++; if (dbg_state !== 2'd0) $display("FAIL held_final_idle got %0d exp 0", dbg_state); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_same_addr();
        test_diff_addr();
        test_zero_reg();
        test_sweep();
        test_reset_mid_sweep();
        test_held_clr_req();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, data width of each entry and bus.
REQ-002 SHALL provide parameter ADDR_W, default 5, address width; depth = 2**ADDR_W entries.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports ra, rb  input  ADDR_W  read addresses, ports A and B.
REQ-006 SHALL have ports bus_a, bus_b  output  DATA_W  read data, ports A and B.
REQ-007 SHALL have ports we0, we1  input  1  write enables, write ports 0 and 1.
REQ-008 SHALL have ports rw0, rw1  input  ADDR_W  write addresses, write ports 0 and 1.
REQ-009 SHALL have ports wd0, wd1  input  DATA_W  write data, write ports 0 and 1.
REQ-010 SHALL have port clr_req  input  1  request to start a runtime clear sweep.
REQ-011 SHALL have port clr_busy  output  1  high while the sweep runs.
REQ-012 SHALL have port clr_done  output  1  one-cycle pulse when the sweep completes.

Function
REQ-013 Reads SHALL be combinational, zero latency, from the array at ra/rb.
REQ-014 Write-through bypass: if weN=1 and rwN equals a read address, that bus SHALL return wdN in the same cycle.
REQ-015 Writes SHALL commit on the rising edge when weN=1 and clr_busy=0.
REQ-016 Both ports writing the same address in one cycle: port 1 SHALL win, both in the array and on the bypass.
REQ-017 Writes to different addresses in one cycle SHALL both commit.
REQ-018 Clear FSM states SHALL be IDLE, SWEEP, DONE; reset state IDLE.
REQ-019 IDLE->SWEEP when clr_req=1; pointer loads 0; clr_busy asserts the next cycle.
REQ-020 SWEEP SHALL zero entry[pointer] each cycle and increment the pointer; after entry 2**ADDR_W-1 -> DONE.
REQ-021 A sweep SHALL take exactly 2**ADDR_W cycles with clr_busy=1 (32 at default).
REQ-022 DONE SHALL assert clr_done for one cycle, clr_busy=0, then -> IDLE unconditionally.
REQ-023 clr_req while in SWEEP or DONE SHALL be ignored; it is not queued.
REQ-024 During SWEEP, write ports SHALL be ignored and the bypass disabled; reads return current array contents.
REQ-025 Pointer wrap SHALL NOT occur; the sweep ends on the last index and never restarts without a new clr_req.

Reset
REQ-026 rst_n=0 SHALL immediately clear all entries to 0 without waiting for a clock.
REQ-027 rst_n=0 SHALL force FSM to IDLE, pointer to 0, clr_busy=0, clr_done=0.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep with no clr_done pulse.
REQ-029 Write enables SHALL be ignored while rst_n=0; first write commits on the first edge after release.

Configuration
REQ-030 Macro REGFILE_MP_ZERO_REG_EN defined: entry 0 SHALL always read 0, writes to address 0 SHALL be discarded, bypass SHALL NOT apply to address 0.
REQ-031 Macro undefined: entry 0 SHALL behave as an ordinary read/write register.

Verification
REQ-032 Reset, we0=1 rw0=3 wd0=0xDEADBEEF, ra=3 same cycle -> bus_a=0xDEADBEEF combinationally; next cycle, we0=0 -> bus_a still 0xDEADBEEF.
REQ-033 we0=1 rw0=7 wd0=0x11, we1=1 rw1=7 wd1=0x22, rb=7 -> bus_b=0x22 that cycle; entry 7 holds 0x22 afterwards.
REQ-034 Fill entries 1..31 with index value, pulse clr_req -> clr_busy high 32 cycles, clr_done one pulse, all entries read 0; we0 rw0=5 wd0=0x55 mid-sweep -> entry 5 reads 0 afterwards.
REQ-035 Start sweep, drop rst_n after 10 busy cycles -> clr_busy=0 immediately, no clr_done, all entries 0.
REQ-036 With REGFILE_MP_ZERO_REG_EN: we0=1 rw0=0 wd0=0xFFFFFFFF, ra=0 -> bus_a=0 same and next cycle; without macro -> bus_a=0xFFFFFFFF.
REQ-037 clr_req held high through a full sweep -> exactly one clr_done pulse, then a new sweep starts from IDLE.
